// File: rtl/axi_lite_to_native_slave_pkg.sv
// Shared types and response codes for the AXI-Lite to native-port bridge.
// The FSM state and arbitration direction live here so the bench can name them.
package axi_lite_to_native_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_COLLECT = 3'd1,
        ST_NATIVE     = 3'd2,
        ST_RESP_B     = 3'd3,
        ST_RESP_R     = 3'd4
    } state_t;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_t;

endpackage

// File: rtl/axi_lite_to_native_slave.sv
// AXI4-Lite responder driving a single-beat native request port, one transaction in flight.
// Requests are range/alignment checked and native accesses are aborted after a timeout.
//
//  state         | meaning
//  --------------+----------------------------------------------------------
//  ST_IDLE       | no request held; AR or AW/W may be accepted
//  ST_WR_COLLECT | one of AW/W latched, waiting for the other
//  ST_NATIVE     | request complete; nm_valid high unless checks skipped it
//  ST_RESP_B     | write response held until s_bready
//  ST_RESP_R     | read response held until s_rready
module axi_lite_to_native_slave
    import axi_lite_to_native_slave_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE      = '0,
    parameter logic [ADDR_W-1:0] ADDR_SIZE      = 'h1000,
    parameter int unsigned       TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic [2:0]            s_awprot,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic [2:0]            s_arprot,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  nm_valid,
    output logic                  nm_rw,
    output logic [ADDR_W-1:0]     nm_addr,
    output logic [DATA_W-1:0]     nm_wrdata,
    output logic [DATA_W/8-1:0]   nm_wstrb,
    input  logic                  nm_ready,
    input  logic [DATA_W-1:0]     nm_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // One extra bit so BASE+SIZE reaching the top of the address space does not wrap.
    localparam logic [ADDR_W:0] RANGE_LO = {1'b0, ADDR_BASE};
    localparam logic [ADDR_W:0] RANGE_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    state_t              state, state_nxt;
    dir_t                ptr;
    logic                live, aw_full, w_full, rw_q, err_q, skip_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [1:0]          resp_q;
    logic [TO_W-1:0]     tmo_cnt;

    logic                wr_sel, rd_sel, aw_hs, w_hs, ar_hs, req_done, tmo_hit, native_done;
    logic [ADDR_W-1:0]   req_addr;
    logic [STRB_W-1:0]   req_strb;
    logic                req_err;
    logic                unused_prot;

    assign unused_prot = ^{s_awprot, s_arprot};

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign ar_hs = s_arvalid & s_arready;

    assign req_done = ((state == ST_IDLE) && (ar_hs || (aw_hs && w_hs))) ||
                      ((state == ST_WR_COLLECT) && (aw_full || aw_hs) && (w_full || w_hs));
    assign req_addr = ar_hs ? s_araddr : (aw_hs ? s_awaddr : addr_q);
    assign req_strb = w_hs ? s_wstrb : wstrb_q;
    assign req_err  = ({1'b0, req_addr} < RANGE_LO) || ({1'b0, req_addr} >= RANGE_HI) ||
                      (req_addr[1:0] != 2'b00);

    assign tmo_hit     = TO_EN && (tmo_cnt == TO_LAST) && !nm_ready;
    assign native_done = (state == ST_NATIVE) && (skip_q || nm_ready || tmo_hit);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ar_hs || (aw_hs && w_hs)) state_nxt = ST_NATIVE;
                else if (aw_hs || w_hs)       state_nxt = ST_WR_COLLECT;
            end
            ST_WR_COLLECT: if (req_done)    state_nxt = ST_NATIVE;
            ST_NATIVE:     if (native_done) state_nxt = rw_q ? ST_RESP_B : ST_RESP_R;
            ST_RESP_B:     if (s_bready)    state_nxt = ST_IDLE;
            ST_RESP_R:     if (s_rready)    state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_sel    = (s_awvalid || s_wvalid) && (!s_arvalid || (ptr == DIR_WRITE));
        rd_sel    = s_arvalid && !wr_sel;
        s_arready = live && (state == ST_IDLE) && !wr_sel;
        s_awready = live && !aw_full &&
                    ((state == ST_WR_COLLECT) || ((state == ST_IDLE) && !rd_sel));
        s_wready  = live && !w_full &&
                    ((state == ST_WR_COLLECT) || ((state == ST_IDLE) && !rd_sel));
        s_bvalid  = (state == ST_RESP_B);
        s_rvalid  = (state == ST_RESP_R);
        s_bresp   = resp_q;
        s_rresp   = resp_q;
        s_rdata   = rdata_q;
        nm_valid  = (state == ST_NATIVE) && !skip_q;
        nm_rw     = nm_valid && rw_q;
        nm_addr   = nm_valid ? (addr_q - ADDR_BASE) : '0;
        nm_wrdata = nm_valid ? wdata_q : '0;
        nm_wstrb  = nm_rw ? wstrb_q : '0;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            live    <= 1'b0;
            ptr     <= DIR_WRITE;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            tmo_cnt <= '0;
        end else begin
            live    <= 1'b1;
            aw_full <= (aw_full | aw_hs) & ~req_done;
            w_full  <= (w_full | w_hs) & ~req_done;
            if (ar_hs) begin
                addr_q <= s_araddr;
                rw_q   <= 1'b0;
            end else if (aw_hs || w_hs) begin
                rw_q   <= 1'b1;
            end
            if (aw_hs) addr_q <= s_awaddr;
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            // A write with no enabled bytes completes OKAY without touching the native side.
            if (req_done) begin
                err_q  <= req_err;
                skip_q <= req_err || (!ar_hs && (req_strb == '0));
            end
            if ((state == ST_NATIVE) && !nm_ready) tmo_cnt <= tmo_cnt + 1'b1;
            else                                   tmo_cnt <= '0;
            // Leaving NATIVE without nm_ready and without a skip can only be a timeout.
            if (native_done) begin
                if (err_q || (!skip_q && !nm_ready)) begin
                    resp_q  <= RESP_SLVERR;
                    rdata_q <= '0;
                end else begin
                    resp_q  <= RESP_OKAY;
                    rdata_q <= (skip_q || rw_q) ? '0 : nm_rdata;
                end
            end
            if ((s_bvalid && s_bready) || (s_rvalid && s_rready))
                ptr <= (ptr == DIR_WRITE) ? DIR_READ : DIR_WRITE;
        end
    end

endmodule

// File: tb/tb_axi_lite_to_native_slave.sv
// Scoreboard bench for axi_lite_to_native_slave: expected responses are queued as
// requests are driven and compared when the B/R channel delivers them.
module tb_axi_lite_to_native_slave;
    import axi_lite_to_native_slave_pkg::*;

    logic        aclk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, nm_rdata = '0;
    logic [2:0]  s_awprot = '0, s_arprot = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0;
    logic        s_rready = 1'b0, nm_ready = 1'b0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, nm_valid, nm_rw;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, nm_addr, nm_wrdata;
    logic [3:0]  nm_wstrb;
    logic [110:0] outs;

    typedef struct {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 aclk = ~aclk;

    axi_lite_to_native_slave #(
        .ADDR_W(32), .DATA_W(32), .ADDR_BASE(32'h0), .ADDR_SIZE(32'h1000), .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk(aclk), .resetn(resetn),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .nm_valid(nm_valid), .nm_rw(nm_rw), .nm_addr(nm_addr), .nm_wrdata(nm_wrdata),
        .nm_wstrb(nm_wstrb), .nm_ready(nm_ready), .nm_rdata(nm_rdata)
    );

    assign outs = {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp,
                   s_rdata, nm_valid, nm_rw, nm_addr, nm_wrdata, nm_wstrb};

    task automatic cyc();
        @(posedge aclk); #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sb.delete();
        cyc(); cyc();
        resetn = 1'b1;
        cyc(); cyc();
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit done = 1'b0;
        s_araddr = a; s_arvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            done = s_arready;
            cyc();
        end
        s_arvalid = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL ar_accept addr=%h: arready never 1", a); end
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input bit do_aw, input bit do_w);
        bit aw_hs, w_hs;
        if (do_aw) begin s_awaddr = a; s_awvalid = 1'b1; end
        if (do_w)  begin s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; end
        for (int n = 0; n < 20 && (s_awvalid || s_wvalid); n++) begin
            #1;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            cyc();
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid = 1'b0;
        end
        total++;
        if (s_awvalid || s_wvalid) begin
            bad++; $display("FAIL wr_accept addr=%h: awvalid=%b wvalid=%b still pending", a, s_awvalid, s_wvalid);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic native_serve(input int dly, input logic [31:0] rd, input logic rw,
                                input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        logic [68:0] snap;
        bit stable = 1'b1;
        for (int n = 0; n < 20 && !nm_valid; n++) cyc();
        total++;
        if (!nm_valid) begin bad++; $display("FAIL native_start: nm_valid=0 required 1"); return; end
        total++;
        if (nm_rw !== rw || nm_addr !== a || nm_wstrb !== st || (rw && nm_wrdata !== wd)) begin
            bad++;
            $display("FAIL native_req: rw=%b addr=%h wdata=%h strb=%h required rw=%b addr=%h wdata=%h strb=%h",
                     nm_rw, nm_addr, nm_wrdata, nm_wstrb, rw, a, wd, st);
        end
        snap = {nm_rw, nm_addr, nm_wrdata, nm_wstrb};
        for (int i = 0; i < dly; i++) begin
            cyc();
            if (!nm_valid || snap !== {nm_rw, nm_addr, nm_wrdata, nm_wstrb}) stable = 1'b0;
        end
        total++;
        if (!stable) begin bad++; $display("FAIL native_hold: request changed before nm_ready"); end
        nm_rdata = rd; nm_ready = 1'b1;
        cyc();
        nm_ready = 1'b0; nm_rdata = '0;
        total++;
        if (nm_valid !== 1'b0) begin bad++; $display("FAIL native_drop: nm_valid=%b required 0", nm_valid); end
    endtask

    task automatic wait_resp(input string name);
        exp_t e;
        s_bready = 1'b1; s_rready = 1'b1;
        #1;
        for (int n = 0; n < 40 && !(s_bvalid || s_rvalid); n++) cyc();
        total++;
        if (!(s_bvalid || s_rvalid)) begin
            bad++; $display("FAIL %s: no response, bvalid=0 rvalid=0 required one high", name);
            s_bready = 1'b0; s_rready = 1'b0;
            return;
        end
        if (sb.size() == 0) begin
            bad++; $display("FAIL %s: response with empty scoreboard", name);
            s_bready = 1'b0; s_rready = 1'b0;
            return;
        end
        e = sb.pop_front();
        if (s_bvalid !== e.wr || (e.wr ? s_bresp : s_rresp) !== e.resp ||
            (!e.wr && s_rdata !== e.rdata)) begin
            bad++;
            $display("FAIL %s: bvalid=%b rvalid=%b resp=%b rdata=%h required wr=%b resp=%b rdata=%h",
                     name, s_bvalid, s_rvalid, e.wr ? s_bresp : s_rresp, s_rdata, e.wr, e.resp, e.rdata);
        end
        cyc();
        s_bready = 1'b0; s_rready = 1'b0;
        total++;
        if (s_bvalid || s_rvalid) begin
            bad++; $display("FAIL %s_release: bvalid=%b rvalid=%b required 0", name, s_bvalid, s_rvalid);
        end
    endtask

    task automatic nm_quiet(input string name);
        bit quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (nm_valid) quiet = 1'b0;
            cyc();
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL %s: nm_valid rose, required 0", name); end
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs: outs=%h required 0", outs); end
        cyc(); cyc();
        resetn = 1'b1;
        cyc(); cyc();
        total++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, nm_valid} !== 6'b111000) begin
            bad++;
            $display("FAIL reset_idle: aw/w/ar ready=%b%b%b bvalid=%b rvalid=%b nm_valid=%b required 111000",
                     s_awready, s_wready, s_arready, s_bvalid, s_rvalid, nm_valid);
        end
    endtask

    task automatic test_read();
        sb.push_back('{wr: 1'b0, resp: RESP_OKAY, rdata: 32'hDEADBEEF});
        send_ar(32'h10);
        native_serve(3, 32'hDEADBEEF, 1'b0, 32'h10, 32'h0, 4'h0);
        total++;
        if (s_rvalid !== 1'b1) begin bad++; $display("FAIL read_latency: rvalid=%b required 1", s_rvalid); end
        wait_resp("read_ok");
    endtask

    task automatic test_split_write();
        sb.push_back('{wr: 1'b1, resp: RESP_OKAY, rdata: 32'h0});
        send_write(32'h0, 32'hA5A5A5A5, 4'b0011, 1'b0, 1'b1);
        total++;
        if ({s_arready, s_wready, nm_valid} !== 3'b000) begin
            bad++;
            $display("FAIL w_latched: arready=%b wready=%b nm_valid=%b required 000", s_arready, s_wready, nm_valid);
        end
        cyc();
        send_write(32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
        native_serve(0, 32'h0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011);
        wait_resp("split_write");
    endtask

    task automatic test_errors();
        logic [31:0] bad_addrs [2] = '{32'h2000, 32'h1000};
        foreach (bad_addrs[i]) begin
            sb.push_back('{wr: 1'b0, resp: RESP_SLVERR, rdata: 32'h0});
            send_ar(bad_addrs[i]);
            nm_quiet("rd_range_quiet");
            wait_resp("rd_range_err");
        end
        sb.push_back('{wr: 1'b1, resp: RESP_SLVERR, rdata: 32'h0});
        send_write(32'h3, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1);
        nm_quiet("wr_align_quiet");
        wait_resp("wr_align_err");
        sb.push_back('{wr: 1'b1, resp: RESP_OKAY, rdata: 32'h0});
        send_write(32'h30, 32'h1234_5678, 4'h0, 1'b1, 1'b1);
        nm_quiet("wr_nostrb_quiet");
        wait_resp("wr_nostrb");
    endtask

    task automatic test_timeout();
        int cnt = 0;
        sb.push_back('{wr: 1'b0, resp: RESP_SLVERR, rdata: 32'h0});
        send_ar(32'h80);
        while (nm_valid && cnt < 20) begin cnt++; cyc(); end
        total++;
        if (cnt != 8) begin bad++; $display("FAIL tmo_len: nm_valid cycles=%0d required 8", cnt); end
        total++;
        if (s_rvalid !== 1'b1 || s_rresp !== RESP_SLVERR) begin
            bad++; $display("FAIL tmo_resp: rvalid=%b rresp=%b required 1 10", s_rvalid, s_rresp);
        end
        nm_rdata = 32'h1234_5678; nm_ready = 1'b1;
        cyc();
        nm_ready = 1'b0; nm_rdata = '0;
        total++;
        if (nm_valid !== 1'b0 || s_rvalid !== 1'b1 || s_rresp !== RESP_SLVERR || s_rdata !== 32'h0) begin
            bad++;
            $display("FAIL late_ready: nm_valid=%b rvalid=%b rresp=%b rdata=%h required 0 1 10 0",
                     nm_valid, s_rvalid, s_rresp, s_rdata);
        end
        wait_resp("timeout");
    endtask

    task automatic test_arbitration();
        bit hold_ok = 1'b1;
        do_reset();
        s_araddr = 32'h40; s_arvalid = 1'b1;
        s_awaddr = 32'h44; s_awvalid = 1'b1;
        s_wdata = 32'h1111_2222; s_wstrb = 4'hF; s_wvalid = 1'b1;
        #1;
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b110) begin
            bad++; $display("FAIL arb_first: aw/w/ar ready=%b%b%b required 110", s_awready, s_wready, s_arready);
        end
        sb.push_back('{wr: 1'b1, resp: RESP_OKAY, rdata: 32'h0});
        cyc();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        native_serve(1, 32'h0, 1'b1, 32'h44, 32'h1111_2222, 4'hF);
        s_awaddr = 32'h48; s_wdata = 32'h3333_4444; s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!s_bvalid || s_bresp !== RESP_OKAY || s_awready || s_wready || s_arready || nm_valid)
                hold_ok = 1'b0;
            cyc();
        end
        total++;
        if (!hold_ok) begin bad++; $display("FAIL b_hold: response unstable or new request accepted"); end
        wait_resp("arb_write1");
        #1;
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b001) begin
            bad++; $display("FAIL arb_second: aw/w/ar ready=%b%b%b required 001", s_awready, s_wready, s_arready);
        end
        sb.push_back('{wr: 1'b0, resp: RESP_OKAY, rdata: 32'hCAFEF00D});
        cyc();
        s_arvalid = 1'b0;
        native_serve(0, 32'hCAFEF00D, 1'b0, 32'h40, 32'h0, 4'h0);
        wait_resp("arb_read");
        sb.push_back('{wr: 1'b1, resp: RESP_OKAY, rdata: 32'h0});
        send_write(32'h48, 32'h3333_4444, 4'hF, 1'b1, 1'b1);
        native_serve(0, 32'h0, 1'b1, 32'h48, 32'h3333_4444, 4'hF);
        wait_resp("arb_write2");
    endtask

    task automatic test_reset_mid_op();
        send_ar(32'h100);
        for (int n = 0; n < 5 && !nm_valid; n++) cyc();
        resetn = 1'b0;
        #1;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL rst_async: outs=%h required 0", outs); end
        sb.delete();
        cyc();
        resetn = 1'b1;
        cyc(); cyc(); cyc();
        total++;
        if (s_rvalid || s_bvalid || nm_valid) begin
            bad++; $display("FAIL rst_no_resp: rvalid=%b bvalid=%b nm_valid=%b required 000", s_rvalid, s_bvalid, nm_valid);
        end
        sb.push_back('{wr: 1'b0, resp: RESP_OKAY, rdata: 32'h0BAD_F00D});
        send_ar(32'h10);
        native_serve(2, 32'h0BAD_F00D, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_resp("read_after_rst");
    endtask

    initial begin
        test_reset();
        test_read();
        test_split_write();
        test_errors();
        test_timeout();
        test_arbitration();
        test_reset_mid_op();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: %0d responses missing, required 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
